eth_tx_arbiter: RTL
===================

# eth_tx_arbiter

Frame-granular round-robin arbiter that shares the single Ethernet TX AXI Stream input of `eth_top` among `NumReq` independent requesters, e.g. iDMA channels or a control-frame generator. A grant is held from the first beat of a frame until its `tlast` handshake. After every frame, a programmable idle gap runs before the next grant. The block sits directly in front of the TX downsizer and runs in the 125 MHz `clk_i` domain.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters, 2..8.
- `axi_stream_req_t`, default `eth_top_pkg::s_req_t`: AXI Stream request struct, shared by the inputs and the output.
- `axi_stream_rsp_t`, default `eth_top_pkg::s_rsp_t`: AXI Stream response struct.
- `IfgCycles`, default 2: idle cycles forced after each frame's `tlast`, 0..255. A value of 0 disables the gap.

Ports:
- `clk_i` input, 1: clock.
- `rst_ni` input, 1: reset. One clock; reset is asynchronous and active-low.
- `req_i` input, [NumReq] x `axi_stream_req_t`: requester streams.
- `rsp_o` output, [NumReq] x `axi_stream_rsp_t`: requester responses.
- `req_o` output, `axi_stream_req_t`: merged stream toward `eth_top` `tx_axis_req_i`.
- `rsp_i` input, `axi_stream_rsp_t`: response from `eth_top`.
- `grant_o` output, NumReq: one-hot owner of the current frame; 0 when no frame is in progress.
- `busy_o` output, 1: high in LOCK or GAP.
- `frame_cnt_o` output, [NumReq] x 16: completed frames per requester (see Configuration).
- `cnt_clr_i` input, 1: synchronous clear of `frame_cnt_o`.

## Operation
The block is a state machine with three states: IDLE, LOCK and GAP.

- **IDLE**
  - All `rsp_o[i].tready` = 0 and `req_o.tvalid` = 0.
  - When any `req_i[i].tvalid` is high, select the first valid index at or after `rr_ptr`, wrapping modulo `NumReq`.
  - Register `sel`, set `grant_o` = one-hot(`sel`) and `rr_ptr` = (`sel`+1) mod `NumReq`, then go to LOCK.
- **LOCK**
  - Combinational pass-through: `req_o` = `req_i[sel]`, `rsp_o[sel]` = `rsp_i`, and `tready` = 0 for every other requester.
  - On `req_o.tvalid & rsp_i.tready & req_o.tlast`:
    - go to GAP with `gap_cnt` = `IfgCycles`-1 if `IfgCycles` > 0, otherwise go to IDLE;
    - clear `grant_o` in the same edge.
  - The grant never moves mid-frame, even if `sel` deasserts `tvalid` for any number of cycles.
- **GAP**
  - All readies are 0 and `req_o.tvalid` = 0.
  - `gap_cnt` decrements each cycle; move to IDLE when it is 0.
- **Fairness**
  - Each requester waits at most `NumReq`-1 frames between its own grants.
  - A requester that is not valid during the IDLE arbitration cycle is skipped; the pointer does not wait for it.
- **Reset**
  - Every output goes to zero: `req_o` all fields 0, all `rsp_o` 0, `grant_o` 0, `busy_o` 0, `frame_cnt_o` 0.
  - State returns to IDLE and `rr_ptr` to 0.
  - A frame cut by reset mid-frame is left truncated downstream. Recovery from that is the framing layer's responsibility.

## Timing
- Arbitration latency is 1 cycle: if `tvalid` rises at cycle t in IDLE, the first beat can appear on `req_o` at t+1.
- The LOCK datapath is purely combinational, so throughput is 1 beat per cycle while `rsp_i.tready` is high.
- Frame-to-frame spacing is the `tlast` beat, then `IfgCycles` gap cycles, then 1 IDLE cycle, then the next first beat. With `IfgCycles`=2 that is 3 dead cycles.
- A single-beat frame (`tlast` on the first beat) is legal and follows the same path.
- AXI Stream rules hold on `req_o`: once `tvalid` is asserted in LOCK it is the requester's `tvalid`, so stability is inherited from the requester. No beat is ever duplicated or dropped.

## Configuration
- `ETH_TX_ARB_STATS_EN` defined:
  - `frame_cnt_o[i]` increments on each `tlast` handshake of requester i and wraps from 0xFFFF to 0.
  - `cnt_clr_i` zeroes all counters. A clear wins over an increment in the same cycle.
- Not defined: `frame_cnt_o` is tied to 0, `cnt_clr_i` is ignored, and no counter flops are instantiated.

## Structure
- `eth_tx_arb_pkg` holds:
  - the state enum `arb_state_e` (IDLE, LOCK, GAP);
  - `FrameCntWidth` = 16;
  - `GapCntWidth` = 8.
- Sub-module `eth_tx_arb_rr_sel` is a combinational round-robin picker:
  - inputs: valid vector and `rr_ptr`;
  - outputs: `sel` index and `any_valid`.
- Everything else (state machine, gap counter, mux, stats) lives in `eth_tx_arbiter`.

## Test plan
- **Single requester.** `NumReq`=2; requester 0 sends a 4-beat frame with `rsp_i.tready`=1 and `IfgCycles`=2.
  - First beat on `req_o` 1 cycle after `tvalid`; 4 consecutive beats.
  - `grant_o`=01 during the frame; 2 GAP cycles in which `busy_o`=1 and `tvalid`=0.
- **Contention.** Both requesters continuously valid with 3-beat frames.
  - Grant order 0,1,0,1.
  - No beats interleaved; `rsp_o[1].tready`=0 throughout every frame owned by 0.
- **Back-pressure and bubbles.** `rsp_i.tready` toggles 1010…; requester 0 drops `tvalid` for 5 cycles mid-frame.
  - Grant stays 01; all beats arrive in order with no loss.
  - Requester 1 is not granted until after 0's `tlast` and the gap.
- **Skip and wrap.** `NumReq`=4, `rr_ptr`=3, only requester 1 valid → grant 1, then `rr_ptr`=2.
- **Reset mid-frame.** `rst_ni` low on beat 2 of 5 → `req_o.tvalid`=0 and `grant_o`=0 immediately; after release the next arbitration starts from requester 0.
- **Stats (`ETH_TX_ARB_STATS_EN`).**
  - 3 frames from requester 1 → `frame_cnt_o[1]`=3.
  - `cnt_clr_i` pulsed in the same cycle as a `tlast` → count becomes 0.

Source files
------------

// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the Ethernet TX arbiter, plus the eth_top stream structs it defaults to.
// Optional frame statistics are enabled with ETH_TX_ARB_STATS_EN.
package eth_top_pkg;
    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic        tvalid;
    } s_req_t;

    typedef struct packed {
        logic tready;
    } s_rsp_t;
endpackage

package eth_tx_arb_pkg;
    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        GAP
    } arb_state_e;

    localparam int FrameCntWidth = 16;
    localparam int GapCntWidth   = 8;
endpackage

// File: rtl/eth_tx_arb_rr_sel.sv
// Combinational round-robin picker: the first valid index at or after rr_ptr, wrapping.
module eth_tx_arb_rr_sel #(
    parameter int NumReq   = 2,
    parameter int PtrWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   valid,
    input  logic [PtrWidth-1:0] rr_ptr,
    output logic [PtrWidth-1:0] sel,
    output logic                any_valid
);
    int idx;

    // Walk offsets from far to near so the nearest valid index is written last.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NumReq;
            if (valid[PtrWidth'(idx)]) begin
                sel       = PtrWidth'(idx);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the eth_top TX stream, with a programmable
// inter-frame gap. Per-requester frame counters are built only with ETH_TX_ARB_STATS_EN.
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requesters
//   LOCK  | sel owns req_o until its tlast handshake
//   GAP   | forced idle cycles after a frame
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int  NumReq           = 2,
    parameter type axi_stream_req_t = eth_top_pkg::s_req_t,
    parameter type axi_stream_rsp_t = eth_top_pkg::s_rsp_t,
    parameter int  IfgCycles        = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  axi_stream_req_t [NumReq-1:0]         req_i,
    output axi_stream_rsp_t [NumReq-1:0]         rsp_o,
    output axi_stream_req_t                      req_o,
    input  axi_stream_rsp_t                      rsp_i,
    output logic [NumReq-1:0]                    grant_o,
    output logic                                 busy_o,
    output logic [NumReq-1:0][FrameCntWidth-1:0] frame_cnt_o,
    input  logic                                 cnt_clr_i
);
    localparam int PtrWidth = $clog2(NumReq);

    arb_state_e             state;
    logic [PtrWidth-1:0]    sel;
    logic [PtrWidth-1:0]    rr_ptr;
    logic [PtrWidth-1:0]    pick;
    logic [PtrWidth-1:0]    next_ptr;
    logic [NumReq-1:0]      pick_onehot;
    logic [NumReq-1:0]      req_valid;
    logic                   any_valid;
    logic [GapCntWidth-1:0] gap_cnt;
    logic                   frame_done;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_valid[i] = req_i[i].tvalid;
        end
    end

    eth_tx_arb_rr_sel #(
        .NumReq   (NumReq),
        .PtrWidth (PtrWidth)
    ) u_rr_sel (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .sel       (pick),
        .any_valid (any_valid)
    );

    always_comb begin
        pick_onehot       = '0;
        pick_onehot[pick] = 1'b1;
        next_ptr = (pick == PtrWidth'(NumReq - 1)) ? '0 : pick + 1'b1;
    end

    // Pass-through is purely combinational so a locked frame streams at one beat per cycle.
    always_comb begin
        req_o = '0;
        rsp_o = '0;
        if (state == LOCK) begin
            req_o      = req_i[sel];
            rsp_o[sel] = rsp_i;
        end
    end

    assign frame_done = (state == LOCK) && req_o.tvalid && rsp_i.tready && req_o.tlast;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            sel     <= '0;
            rr_ptr  <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        sel     <= pick;
                        grant_o <= pick_onehot;
                        rr_ptr  <= next_ptr;
                        busy_o  <= 1'b1;
                        state   <= LOCK;
                    end
                end
                LOCK: begin
                    if (frame_done) begin
                        grant_o <= '0;
                        if (IfgCycles > 0) begin
                            gap_cnt <= GapCntWidth'(IfgCycles - 1);
                            state   <= GAP;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [NumReq-1:0][FrameCntWidth-1:0] frame_cnt_q;

    // A clear takes priority over a frame completing in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q[sel] <= frame_cnt_q[sel] + 1'b1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr_i;
    assign frame_cnt_o    = '0;
`endif
endmodule
